// File: rtl/fsab_pkg.sv
// Shared field widths, mode encodings, capacity defaults and payload types.
package fsab_pkg;

  localparam int unsigned DID_W   = 4;
  localparam int unsigned ADDR_W  = 31;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned MASK_W  = 8;

  localparam int unsigned CREDITS = 4;
  localparam int unsigned MAXLEN  = 8;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef struct packed {
    logic              mode;
    logic [DID_W-1:0]  did;
    logic [DID_W-1:0]  subdid;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } fsab_hdr_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } fsab_beat_t;

endpackage

// File: rtl/fsab_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and occupancy count.
module fsab_sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer wrap and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless once pointers are reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fsab_arbiter_fifo.sv
// Per-client request FIFO: assembles reads/writes, holds them until the
// arbiter grants the bus, then replays header and data beats in order.
module fsab_arbiter_fifo
  import fsab_pkg::*;
#(
  parameter int unsigned MYINDEX = 0,
  parameter int unsigned CREDITS = fsab_pkg::CREDITS,
  parameter int unsigned MAXLEN  = fsab_pkg::MAXLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inp_valid,
  input  logic              inp_mode,
  input  logic [DID_W-1:0]  inp_did,
  input  logic [DID_W-1:0]  inp_subdid,
  input  logic [ADDR_W-1:0] inp_addr,
  input  logic [LEN_W-1:0]  inp_len,
  input  logic [DATA_W-1:0] inp_data,
  input  logic [MASK_W-1:0] inp_mask,
  output logic              inp_credit,
  output logic              out_valid,
  output logic              out_mode,
  output logic [DID_W-1:0]  out_did,
  output logic [DID_W-1:0]  out_subdid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [LEN_W-1:0]  out_len,
  output logic [DATA_W-1:0] out_data,
  output logic [MASK_W-1:0] out_mask,
  output logic              empty_b,
  output logic              active,
  input  logic              start
);

  localparam int unsigned HDR_DEPTH = CREDITS;
  localparam int unsigned BT_DEPTH  = CREDITS * MAXLEN;
  localparam int unsigned HCNT_W    = $clog2(HDR_DEPTH + 1);
  localparam int unsigned BCNT_W    = $clog2(BT_DEPTH + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        active_q, active_d;
  logic        out_valid_q, out_valid_d;
  logic        credit_q, credit_d;
  logic        empty_b_q, empty_b_d;
  fsab_hdr_t   out_hdr_q, out_hdr_d;
  fsab_beat_t  out_beat_q, out_beat_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;

  logic        wr_busy_q, wr_busy_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  fsab_hdr_t   wr_hdr_q, wr_hdr_d;

  fsab_hdr_t   inp_hdr, hdr_push_data, hdr_head;
  fsab_beat_t  beat_in, beat_head;
  logic        hdr_push, hdr_pop, hdr_full, hdr_empty;
  logic        beat_push, beat_pop, beat_full, beat_empty;
  logic [HCNT_W-1:0] hdr_count;
  logic [BCNT_W-1:0] beat_count;
  logic        hdr_push_ok;
  logic        grant_ok;

  assign inp_hdr = '{mode: inp_mode, did: inp_did, subdid: inp_subdid,
                     addr: inp_addr, len: inp_len};
  assign beat_in = '{data: inp_data, mask: inp_mask};

  fsab_sync_fifo #(.WIDTH($bits(fsab_hdr_t)), .DEPTH(HDR_DEPTH)) u_hdr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (hdr_push),
    .data_i  (hdr_push_data),
    .pop_i   (hdr_pop),
    .data_o  (hdr_head),
    .count_o (hdr_count),
    .full_o  (hdr_full),
    .empty_o (hdr_empty)
  );

  fsab_sync_fifo #(.WIDTH($bits(fsab_beat_t)), .DEPTH(BT_DEPTH)) u_beat_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (beat_push),
    .data_i  (beat_in),
    .pop_i   (beat_pop),
    .data_o  (beat_head),
    .count_o (beat_count),
    .full_o  (beat_full),
    .empty_o (beat_empty)
  );

  assign hdr_push_ok = hdr_push && !hdr_full;
  assign grant_ok    = (state_q == ST_IDLE) && start && empty_b_q && !active_q;

  // Input assembly: headers are staged until the last write beat arrives.
  always_comb begin
    wr_busy_d     = wr_busy_q;
    wr_cnt_d      = wr_cnt_q;
    wr_hdr_d      = wr_hdr_q;
    hdr_push      = 1'b0;
    hdr_push_data = wr_hdr_q;
    beat_push     = 1'b0;
    if (inp_valid) begin
      if (!wr_busy_q) begin
        if (inp_mode == MODE_READ) begin
          hdr_push      = 1'b1;
          hdr_push_data = inp_hdr;
        end else begin
          beat_push = 1'b1;
          if (inp_len <= LEN_W'(1)) begin
            hdr_push      = 1'b1;
            hdr_push_data = inp_hdr;
          end else begin
            wr_busy_d = 1'b1;
            wr_cnt_d  = LEN_W'(1);
            wr_hdr_d  = inp_hdr;
          end
        end
      end else begin
        beat_push = 1'b1;
        wr_cnt_d  = wr_cnt_q + LEN_W'(1);
        if ((wr_cnt_q + LEN_W'(1)) == wr_hdr_q.len) begin
          hdr_push  = 1'b1;
          wr_busy_d = 1'b0;
        end
      end
    end
  end

  // Issue FSM: latch the oldest header on grant, stream beats, return credit.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    out_valid_d = out_valid_q;
    out_hdr_d   = out_hdr_q;
    out_beat_d  = out_beat_q;
    beat_cnt_d  = beat_cnt_q;
    credit_d    = 1'b0;
    hdr_pop     = 1'b0;
    beat_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_ok) begin
          state_d     = ST_ISSUE;
          active_d    = 1'b1;
          out_valid_d = 1'b1;
          out_hdr_d   = hdr_head;
          hdr_pop     = 1'b1;
          beat_cnt_d  = LEN_W'(1);
          if (hdr_head.mode == MODE_WRITE) begin
            out_beat_d = beat_head;
            beat_pop   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (out_hdr_q.mode == MODE_READ || beat_cnt_q >= out_hdr_q.len) begin
          state_d     = ST_IDLE;
          active_d    = 1'b0;
          out_valid_d = 1'b0;
          credit_d    = 1'b1;
        end else begin
          out_beat_d = beat_head;
          beat_pop   = 1'b1;
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    empty_b_d = (hdr_count + HCNT_W'(hdr_push_ok) - HCNT_W'(hdr_pop)) != '0;
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      active_q    <= 1'b0;
      out_valid_q <= 1'b0;
      credit_q    <= 1'b0;
      empty_b_q   <= 1'b0;
      out_hdr_q   <= '0;
      out_beat_q  <= '0;
      beat_cnt_q  <= '0;
      wr_busy_q   <= 1'b0;
      wr_cnt_q    <= '0;
      wr_hdr_q    <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      out_valid_q <= out_valid_d;
      credit_q    <= credit_d;
      empty_b_q   <= empty_b_d;
      out_hdr_q   <= out_hdr_d;
      out_beat_q  <= out_beat_d;
      beat_cnt_q  <= beat_cnt_d;
      wr_busy_q   <= wr_busy_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_hdr_q    <= wr_hdr_d;
    end
  end

  // Simulation-only protocol checks: overflow and storage integrity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(hdr_push && hdr_full))
        else $error("fsab_arbiter_fifo[%0d]: transaction overflow, dropped", MYINDEX);
      assert (!(beat_push && beat_full))
        else $error("fsab_arbiter_fifo[%0d]: data beat overflow, dropped", MYINDEX);
      assert (!(hdr_pop && hdr_empty))
        else $error("fsab_arbiter_fifo[%0d]: header pop while empty", MYINDEX);
      assert (!(beat_pop && beat_empty))
        else $error("fsab_arbiter_fifo[%0d]: beat pop while empty", MYINDEX);
      assert (!(grant_ok && hdr_head.mode == MODE_WRITE &&
                beat_count < BCNT_W'(hdr_head.len)))
        else $error("fsab_arbiter_fifo[%0d]: write granted without its beats", MYINDEX);
    end
  end

  assign inp_credit = credit_q;
  assign out_valid  = out_valid_q;
  assign out_mode   = out_hdr_q.mode;
  assign out_did    = out_hdr_q.did;
  assign out_subdid = out_hdr_q.subdid;
  assign out_addr   = out_hdr_q.addr;
  assign out_len    = out_hdr_q.len;
  assign out_data   = out_beat_q.data;
  assign out_mask   = out_beat_q.mask;
  assign empty_b    = empty_b_q;
  assign active     = active_q;

endmodule

// File: tb/tb_fsab_arbiter_fifo.sv
// Directed bench for fsab_arbiter_fifo: read, write, full queue, ignored
// grants and reset during issue.
module tb_fsab_arbiter_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inp_valid = 1'b0;
  logic        inp_mode = 1'b0;
  logic [3:0]  inp_did = '0;
  logic [3:0]  inp_subdid = '0;
  logic [30:0] inp_addr = '0;
  logic [3:0]  inp_len = '0;
  logic [63:0] inp_data = '0;
  logic [7:0]  inp_mask = '0;
  logic        inp_credit;
  logic        out_valid, out_mode;
  logic [3:0]  out_did, out_subdid;
  logic [30:0] out_addr;
  logic [3:0]  out_len;
  logic [63:0] out_data;
  logic [7:0]  out_mask;
  logic        empty_b, active;
  logic        start = 1'b0;

  int tests = 0;
  int fails = 0;
  int credit_pulses = 0;

  always #5 clk = ~clk;

  fsab_arbiter_fifo #(.MYINDEX(0), .CREDITS(4), .MAXLEN(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .inp_valid  (inp_valid),
    .inp_mode   (inp_mode),
    .inp_did    (inp_did),
    .inp_subdid (inp_subdid),
    .inp_addr   (inp_addr),
    .inp_len    (inp_len),
    .inp_data   (inp_data),
    .inp_mask   (inp_mask),
    .inp_credit (inp_credit),
    .out_valid  (out_valid),
    .out_mode   (out_mode),
    .out_did    (out_did),
    .out_subdid (out_subdid),
    .out_addr   (out_addr),
    .out_len    (out_len),
    .out_data   (out_data),
    .out_mask   (out_mask),
    .empty_b    (empty_b),
    .active     (active),
    .start      (start)
  );

  always @(posedge clk) if (inp_credit === 1'b1) credit_pulses <= credit_pulses + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic mode, input logic [3:0] did, input logic [30:0] addr,
                      input logic [3:0] len, input logic [63:0] data);
    inp_valid = 1'b1;
    inp_mode  = mode;
    inp_did   = did;
    inp_subdid = did + 4'd1;
    inp_addr  = addr;
    inp_len   = len;
    inp_data  = data;
    inp_mask  = data[7:0] ^ 8'hF0;
    step();
    inp_valid = 1'b0;
  endtask

  // Expected contents of the full-queue scenario.
  logic        fq_mode [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [30:0] fq_addr [4] = '{31'h10, 31'h20, 31'h30, 31'h40};
  logic [3:0]  fq_len  [4] = '{4'd1, 4'd2, 4'd1, 4'd1};
  logic [63:0] fq_data [4][2] = '{'{64'h0, 64'h0}, '{64'h1, 64'h2},
                                  '{64'h0, 64'h0}, '{64'h99, 64'h0}};

  initial begin
    // Reset state.
    step(); step();
    chk("rst_empty_b", 64'(empty_b), 64'd0);
    chk("rst_active", 64'(active), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_credit", 64'(inp_credit), 64'd0);
    rst = 1'b0;
    step();

    // Grant with nothing stored is ignored.
    start = 1'b1; step(); start = 1'b0;
    chk("ign_empty_active", 64'(active), 64'd0);
    step();
    chk("ign_empty_credit", 64'(inp_credit), 64'd0);

    // Single-beat read.
    beat(1'b0, 4'd3, 31'h100, 4'd1, 64'h0);
    chk("rd_empty_b", 64'(empty_b), 64'd1);
    start = 1'b1; step(); start = 1'b0;
    chk("rd_active", 64'(active), 64'd1);
    chk("rd_valid", 64'(out_valid), 64'd1);
    chk("rd_addr", 64'(out_addr), 64'h100);
    chk("rd_did", 64'(out_did), 64'd3);
    chk("rd_mode", 64'(out_mode), 64'd0);
    chk("rd_empty_b_issue", 64'(empty_b), 64'd0);
    chk("rd_credit_early", 64'(inp_credit), 64'd0);
    step();
    chk("rd_active_end", 64'(active), 64'd0);
    chk("rd_valid_end", 64'(out_valid), 64'd0);
    chk("rd_credit", 64'(inp_credit), 64'd1);
    step();
    chk("rd_credit_once", 64'(inp_credit), 64'd0);

    // Four-beat write with a gap cycle.
    beat(1'b1, 4'd5, 31'h200, 4'd4, 64'hA);
    chk("wr_empty_b1", 64'(empty_b), 64'd0);
    beat(1'b1, 4'd5, 31'h200, 4'd4, 64'hB);
    step();
    beat(1'b1, 4'd5, 31'h200, 4'd4, 64'hC);
    chk("wr_empty_b3", 64'(empty_b), 64'd0);
    beat(1'b1, 4'd5, 31'h200, 4'd4, 64'hD);
    chk("wr_empty_b4", 64'(empty_b), 64'd1);
    start = 1'b1; step(); start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("wr_active_%0d", b), 64'(active), 64'd1);
      chk($sformatf("wr_data_%0d", b), out_data, 64'hA + 64'(b));
      chk($sformatf("wr_mask_%0d", b), 64'(out_mask), 64'((8'hA + 8'(b)) ^ 8'hF0));
      chk($sformatf("wr_len_%0d", b), 64'(out_len), 64'd4);
      chk($sformatf("wr_addr_%0d", b), 64'(out_addr), 64'h200);
      step();
    end
    chk("wr_active_end", 64'(active), 64'd0);
    chk("wr_credit", 64'(inp_credit), 64'd1);

    // Grant during an active window is ignored.
    beat(1'b0, 4'd1, 31'h500, 4'd1, 64'h0);
    beat(1'b0, 4'd2, 31'h600, 4'd1, 64'h0);
    start = 1'b1; step();
    chk("ign_act_addr", 64'(out_addr), 64'h500);
    step(); start = 1'b0;
    chk("ign_act_end", 64'(active), 64'd0);
    chk("ign_act_credit", 64'(inp_credit), 64'd1);
    step();
    chk("ign_act_noresp", 64'(active), 64'd0);
    chk("ign_act_nocredit", 64'(inp_credit), 64'd0);
    chk("ign_act_empty_b", 64'(empty_b), 64'd1);
    start = 1'b1; step(); start = 1'b0;
    chk("ign_act_next", 64'(out_addr), 64'h600);
    step(); step();

    // Full queue, back-to-back grants, arrival order.
    beat(1'b0, 4'd7, fq_addr[0], fq_len[0], 64'h0);
    beat(1'b1, 4'd7, fq_addr[1], fq_len[1], fq_data[1][0]);
    beat(1'b1, 4'd7, fq_addr[1], fq_len[1], fq_data[1][1]);
    beat(1'b0, 4'd7, fq_addr[2], fq_len[2], 64'h0);
    beat(1'b1, 4'd7, fq_addr[3], fq_len[3], fq_data[3][0]);
    chk("full_empty_b", 64'(empty_b), 64'd1);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < int'(fq_len[k]); b++) begin
        chk($sformatf("full_active_%0d_%0d", k, b), 64'(active), 64'd1);
        chk($sformatf("full_addr_%0d_%0d", k, b), 64'(out_addr), 64'(fq_addr[k]));
        chk($sformatf("full_mode_%0d_%0d", k, b), 64'(out_mode), 64'(fq_mode[k]));
        if (fq_mode[k]) chk($sformatf("full_data_%0d_%0d", k, b), out_data, fq_data[k][b]);
        step();
      end
      chk($sformatf("full_credit_%0d", k), 64'(inp_credit), 64'd1);
      chk($sformatf("full_idle_%0d", k), 64'(active), 64'd0);
      if (k < 3) start = 1'b1;
      step(); start = 1'b0;
    end
    chk("full_empty_b_end", 64'(empty_b), 64'd0);
    chk("full_active_end", 64'(active), 64'd0);

    // Reset during beat 2 of an eight-beat write.
    for (int b = 0; b < 8; b++) beat(1'b1, 4'd9, 31'h700, 4'd8, 64'h50 + 64'(b));
    chk("rsti_empty_b", 64'(empty_b), 64'd1);
    start = 1'b1; step(); start = 1'b0;
    chk("rsti_beat1", out_data, 64'h50);
    step();
    chk("rsti_beat2", out_data, 64'h51);
    rst = 1'b1;
    #1;
    chk("rsti_active", 64'(active), 64'd0);
    chk("rsti_empty_b0", 64'(empty_b), 64'd0);
    chk("rsti_valid", 64'(out_valid), 64'd0);
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("rsti_nocredit_%0d", c), 64'(inp_credit), 64'd0);
      chk($sformatf("rsti_idle_%0d", c), 64'(active), 64'd0);
      step();
    end
    chk("rsti_empty_after", 64'(empty_b), 64'd0);

    // Total credit pulses: read, write, two reads, four queued.
    chk("credit_total", 64'(credit_pulses), 64'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
